// File: rtl/er_exec_proof_pkg.sv
// Shared types and constants for the execution-proof monitor (er_exec_proof).
package er_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_FAIL = 2'd3
   } er_state_t;

   localparam logic [15:0] SMEM_BASE     = 16'hA000;
   localparam logic [15:0] SMEM_SIZE     = 16'h4000;
   localparam logic [15:0] RESET_HANDLER = 16'h0000;
   // Secure memory is the half-open window [SMEM_BASE, SMEM_BASE + SMEM_SIZE).
   localparam logic [15:0] SMEM_LAST     = 16'(SMEM_BASE + SMEM_SIZE - 16'd1);

   function automatic logic ranges_overlap(input logic [15:0] a_lo, input logic [15:0] a_hi,
                                           input logic [15:0] b_lo, input logic [15:0] b_hi);
      return (a_lo <= b_hi) && (b_lo <= a_hi);
   endfunction

endpackage

// File: rtl/er_exec_proof_range_check.sv
// Inclusive address window comparator: in_range = lo <= addr <= hi.
module er_range_check (
   input  logic [15:0] addr,
   input  logic [15:0] lo,
   input  logic [15:0] hi,
   output logic        in_range
);

   assign in_range = (addr >= lo) && (addr <= hi);

endmodule

// File: rtl/er_exec_proof.sv
// Proves the executable region ran atomically start-to-end with the output region untouched since.
// Optional macro EXEC_DMA_CHECK_EN adds DMA accesses as violations.
module er_exec_proof
   import er_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] pc,
   input  logic        irq,
   input  logic [15:0] data_addr,
   input  logic        data_wr,
   input  logic [15:0] dma_addr,
   input  logic        dma_en,
   input  logic [15:0] ER_min,
   input  logic [15:0] ER_max,
   input  logic [15:0] OR_min,
   input  logic [15:0] OR_max,
   output logic        exec,
   output logic [15:0] run_cycles
);

   er_state_t   r_state;
   er_state_t   w_state_next;
   logic [15:0] r_prev_pc;
   logic [15:0] r_er_min_sh;
   logic [15:0] r_er_max_sh;
   logic [15:0] r_or_min_sh;
   logic [15:0] r_or_max_sh;
   logic [15:0] r_run_cycles;
   logic        r_exec;

   logic        w_pc_in_er;
   logic        w_data_in_or;
   logic        w_at_entry;
   logic        w_cfg_invalid;
   logic        w_bound_change;
   logic        w_run_viol;
   logic        w_done_viol;
   logic        w_dma_run_viol;
   logic        w_dma_done_viol;

   er_range_check u_pc_in_er (
      .addr     (pc),
      .lo       (ER_min),
      .hi       (ER_max),
      .in_range (w_pc_in_er)
   );

   er_range_check u_data_in_or (
      .addr     (data_addr),
      .lo       (OR_min),
      .hi       (OR_max),
      .in_range (w_data_in_or)
   );

`ifdef EXEC_DMA_CHECK_EN
   logic w_dma_in_or;

   er_range_check u_dma_in_or (
      .addr     (dma_addr),
      .lo       (OR_min),
      .hi       (OR_max),
      .in_range (w_dma_in_or)
   );

   assign w_dma_run_viol  = dma_en;
   assign w_dma_done_viol = dma_en && w_dma_in_or;
`else
   logic w_dma_unused;

   assign w_dma_unused    = ^{dma_addr, dma_en};
   assign w_dma_run_viol  = 1'b0;
   assign w_dma_done_viol = 1'b0;
`endif

   assign w_at_entry     = (pc == ER_min);
   assign w_cfg_invalid  = (ER_min >= ER_max) || (OR_min > OR_max) ||
                           ranges_overlap(ER_min, ER_max, SMEM_BASE, SMEM_LAST) ||
                           (ER_min == RESET_HANDLER);
   assign w_bound_change = (ER_min != r_er_min_sh) || (ER_max != r_er_max_sh) ||
                           (OR_min != r_or_min_sh) || (OR_max != r_or_max_sh);

   // Leaving ER is only legal straight out of its last instruction.
   assign w_run_viol  = irq ||
                        (data_wr && !w_data_in_or && w_pc_in_er) ||
                        (!w_pc_in_er && (r_prev_pc != ER_max)) ||
                        (w_at_entry && (r_prev_pc != ER_min)) ||
                        w_dma_run_viol;
   assign w_done_viol = (data_wr && w_data_in_or && !w_pc_in_er) ||
                        (w_pc_in_er && !w_at_entry) ||
                        w_dma_done_viol;

   always_comb begin
      w_state_next = r_state;
      if (w_cfg_invalid || w_bound_change) begin
         w_state_next = ST_FAIL;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_run_viol)       w_state_next = ST_FAIL;
               else if (!w_pc_in_er) w_state_next = ST_DONE;
            end
            ST_DONE: begin
               if (w_done_viol)     w_state_next = ST_FAIL;
               else if (w_at_entry) w_state_next = ST_RUN;
            end
            default: begin
               if (w_at_entry) w_state_next = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_FAIL;
      else       r_state <= w_state_next;
   end

   // Shadows track the bounds every cycle, including during reset.
   always_ff @(posedge clk) begin
      r_er_min_sh <= ER_min;
      r_er_max_sh <= ER_max;
      r_or_min_sh <= OR_min;
      r_or_max_sh <= OR_max;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_exec       <= 1'b0;
         r_run_cycles <= 16'h0000;
         r_prev_pc    <= 16'h0000;
      end else begin
         r_exec    <= (w_state_next == ST_DONE);
         r_prev_pc <= pc;
         if ((w_state_next == ST_RUN) && (r_state != ST_RUN)) begin
            r_run_cycles <= 16'h0001;
         end else if ((w_state_next == ST_RUN) && (r_run_cycles != 16'hFFFF)) begin
            r_run_cycles <= r_run_cycles + 16'h0001;
         end
      end
   end

   assign exec       = r_exec;
   assign run_cycles = r_run_cycles;

endmodule
